// File: rtl/game_sequencer.sv
// Purpose : pong game-flow FSM (IDLE/SERVE/PLAY/MISS/GAMEOVER[/PAUSE]), frame-locked to the raster.
// Latency : start/pause pin to state change 3 clk25 cycles; hit/miss pulse to score/state 1 cycle.
// Backpr. : none; pulses outside PLAY are dropped, all outputs come from registered state.
//
// Ports:
//   clk25, rst          pixel clock, async active-high reset
//   xpos, ypos          raster position; frame_tick = (0,480)
//   start, pause        raw async pushbuttons (pause only when PAUSE_EN is defined)
//   hit_pulse           one-cycle paddle bounce from the datapath
//   miss_pulse          one-cycle bottom-edge touch from the datapath
//   ball_run/paddle_run motion enables, flash = miss phase, ball_serve = recentre pulse
//   speed, lives, score_bcd (3 BCD digits), state (IDLE=0..PAUSE=5)
// Optional feature macro: PAUSE_EN (adds pause port and PAUSE state).

module game_sequencer #(
  parameter int LIVES          = 3,
  parameter int SERVE_FRAMES   = 60,
  parameter int MISS_FRAMES    = 63,
  parameter int HITS_PER_LEVEL = 8,
  parameter int MAX_SPEED      = 3
) (
  input  logic        clk25,
  input  logic        rst,
  input  logic [9:0]  xpos,
  input  logic [9:0]  ypos,
  input  logic        start,
  input  logic        hit_pulse,
  input  logic        miss_pulse,
`ifdef PAUSE_EN
  input  logic        pause,
`endif
  output logic        ball_run,
  output logic        paddle_run,
  output logic        ball_serve,
  output logic        flash,
  output logic [1:0]  speed,
  output logic [1:0]  lives,
  output logic [11:0] score_bcd,
  output logic [2:0]  state
);

  localparam int MAX_FRAMES = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
  localparam int TW         = $clog2(MAX_FRAMES + 1);
  localparam int HW         = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SERVE    = 3'd1,
    S_PLAY     = 3'd2,
    S_MISS     = 3'd3,
    S_GAMEOVER = 3'd4,
    S_PAUSE    = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      lives_q, lives_d;
  logic [11:0]     score_q, score_d;
  logic [1:0]      speed_q, speed_d;
  logic [HW-1:0]   hit_cnt_q, hit_cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            ball_serve_q, ball_serve_d;

  // start: two-flop synchronizer plus a delayed copy for edge detect
  logic            start_s1_q, start_s1_d;
  logic            start_s2_q, start_s2_d;
  logic            start_prev_q, start_prev_d;
  logic            start_edge;

`ifdef PAUSE_EN
  logic            pause_s1_q, pause_s1_d;
  logic            pause_s2_q, pause_s2_d;
  logic            pause_prev_q, pause_prev_d;
  logic            pause_edge;
`endif

  logic            frame_tick;

  // Saturating three-digit BCD increment
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [3:0] d0, d1, d2;
    d0 = v[3:0];
    d1 = v[7:4];
    d2 = v[11:8];
    if (v != 12'h999) begin
      if (d0 != 4'd9) begin
        d0 = d0 + 4'd1;
      end else begin
        d0 = 4'd0;
        if (d1 != 4'd9) begin
          d1 = d1 + 4'd1;
        end else begin
          d1 = 4'd0;
          d2 = d2 + 4'd1;
        end
      end
    end
    return {d2, d1, d0};
  endfunction

  always_comb begin
    frame_tick   = (xpos == 10'd0) && (ypos == 10'd480);
    start_s1_d   = start;
    start_s2_d   = start_s1_q;
    start_prev_d = start_s2_q;
    start_edge   = start_s2_q & ~start_prev_q;
`ifdef PAUSE_EN
    pause_s1_d   = pause;
    pause_s2_d   = pause_s1_q;
    pause_prev_d = pause_s2_q;
    pause_edge   = pause_s2_q & ~pause_prev_q;
`endif
  end

  // Next-state and counter update
  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    score_d      = score_q;
    speed_d      = speed_q;
    hit_cnt_d    = hit_cnt_q;
    timer_d      = timer_q;
    ball_serve_d = 1'b0;

    case (state_q)
      S_IDLE, S_GAMEOVER: begin
        // A coincident frame_tick is irrelevant here: the timer is loaded, not counted.
        if (start_edge) begin
          state_d      = S_SERVE;
          lives_d      = 2'(LIVES);
          score_d      = 12'h000;
          speed_d      = 2'd0;
          hit_cnt_d    = '0;
          timer_d      = TW'(SERVE_FRAMES);
          ball_serve_d = 1'b1;
        end
      end

      S_SERVE: begin
        if (frame_tick) begin
          if (timer_q == TW'(1)) begin
            state_d = S_PLAY;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
      end

      S_PLAY: begin
        // Miss outranks both a coincident hit and a coincident pause press.
        if (miss_pulse) begin
          state_d = S_MISS;
          lives_d = lives_q - 2'd1;
          timer_d = TW'(MISS_FRAMES);
`ifdef PAUSE_EN
        end else if (pause_edge) begin
          state_d = S_PAUSE;
`endif
        end else if (hit_pulse) begin
          score_d = bcd_inc(score_q);
          if (hit_cnt_q == HW'(HITS_PER_LEVEL - 1)) begin
            hit_cnt_d = '0;
            if (speed_q != 2'(MAX_SPEED)) begin
              speed_d = speed_q + 2'd1;
            end
          end else begin
            hit_cnt_d = hit_cnt_q + HW'(1);
          end
        end
      end

      S_MISS: begin
        if (frame_tick) begin
          if (timer_q == TW'(1)) begin
            if (lives_q == 2'd0) begin
              state_d = S_GAMEOVER;
            end else begin
              state_d      = S_SERVE;
              timer_d      = TW'(SERVE_FRAMES);
              ball_serve_d = 1'b1;
            end
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
      end

      S_PAUSE: begin
`ifdef PAUSE_EN
        if (pause_edge) begin
          state_d = S_PLAY;
        end
`else
        state_d = S_IDLE;
`endif
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lives_q      <= 2'(LIVES);
      score_q      <= 12'h000;
      speed_q      <= 2'd0;
      hit_cnt_q    <= '0;
      timer_q      <= '0;
      ball_serve_q <= 1'b0;
      start_s1_q   <= 1'b0;
      start_s2_q   <= 1'b0;
      start_prev_q <= 1'b0;
`ifdef PAUSE_EN
      pause_s1_q   <= 1'b0;
      pause_s2_q   <= 1'b0;
      pause_prev_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      score_q      <= score_d;
      speed_q      <= speed_d;
      hit_cnt_q    <= hit_cnt_d;
      timer_q      <= timer_d;
      ball_serve_q <= ball_serve_d;
      start_s1_q   <= start_s1_d;
      start_s2_q   <= start_s2_d;
      start_prev_q <= start_prev_d;
`ifdef PAUSE_EN
      pause_s1_q   <= pause_s1_d;
      pause_s2_q   <= pause_s2_d;
      pause_prev_q <= pause_prev_d;
`endif
    end
  end

  // Motion/flash enables decoded from the state register only
  always_comb begin
    ball_run   = 1'b0;
    paddle_run = 1'b0;
    flash      = 1'b0;
    case (state_q)
      S_IDLE, S_SERVE: paddle_run = 1'b1;
      S_PLAY: begin
        ball_run   = 1'b1;
        paddle_run = 1'b1;
      end
      S_MISS:  flash = 1'b1;
      default: ;
    endcase
  end

  assign ball_serve = ball_serve_q;
  assign speed      = speed_q;
  assign lives      = lives_q;
  assign score_bcd  = score_q;
  assign state      = state_q;

endmodule
